// File: rtl/lsm_sequencer.sv
// Load/store-multiple sequencer: walks the IR register list and supplies the
// register number, transfer address and base write-back value to the datapath.
module lsm_sequencer (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IR,
    input  logic [31:0] RN_VAL,
    input  logic        LSM_EN,
    input  logic [2:0]  LSM_IN,
    output logic        LSM_DETECT,
    output logic        LSM_END,
    output logic        BUSY,
    output logic [3:0]  REG_NUM,
    output logic [31:0] ADDR,
    output logic [31:0] WB_VAL
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    localparam logic [2:0] CMD_LOAD  = 3'b001;
    localparam logic [2:0] CMD_NEXT  = 3'b010;
    localparam logic [2:0] CMD_CLEAR = 3'b011;

    state_t      state;
    logic [15:0] mask;
    logic [4:0]  count;

    logic [4:0]  load_count;
    logic [31:0] four_n;
    logic [31:0] load_addr;
    logic [31:0] load_wb;

    assign LSM_DETECT = (IR[27:25] == 3'b100);

    // LOAD-time arithmetic: the lowest address of the block is always the
    // first transfer, so the list is walked upwards for both U settings.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        load_count = '0;
        for (int i = 0; i < 16; i++) begin
            load_count = load_count + 5'(IR[i]);
        end
        four_n = {25'd0, load_count, 2'b00};
        unique case (IR[24:23])
            2'b01:   load_addr = RN_VAL;
            2'b11:   load_addr = RN_VAL + 32'd4;
            2'b00:   load_addr = RN_VAL - four_n + 32'd4;
            default: load_addr = RN_VAL - four_n;
        endcase
        load_wb = IR[23] ? (RN_VAL + four_n) : (RN_VAL - four_n);
    end

    // Priority encode: scanning downwards lets the lowest set bit win.
    always_comb begin
        REG_NUM = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                REG_NUM = 4'(i);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!RST_N) begin
            state   <= ST_IDLE;
            mask    <= '0;
            count   <= '0;
            ADDR    <= '0;
            WB_VAL  <= '0;
            LSM_END <= 1'b0;
            BUSY    <= 1'b0;
        end else if (LSM_EN) begin
            case (LSM_IN)
                CMD_LOAD: begin
                    mask  <= IR[15:0];
                    count <= load_count;
                    ADDR  <= load_addr;
                    if (load_count == 5'd0) begin
                        state   <= ST_DONE;
                        WB_VAL  <= RN_VAL;
                        LSM_END <= 1'b1;
                        BUSY    <= 1'b0;
                    end else begin
                        state   <= ST_ACTIVE;
                        WB_VAL  <= load_wb;
                        LSM_END <= (load_count == 5'd1);
                        BUSY    <= 1'b1;
                    end
                end
                CMD_NEXT: begin
                    if (state == ST_ACTIVE) begin
                        count <= count - 5'd1;
                        ADDR  <= ADDR + 32'd4;
                        if (count == 5'd1) begin
                            state   <= ST_DONE;
                            mask    <= '0;
                            LSM_END <= 1'b1;
                            BUSY    <= 1'b0;
                        end else begin
                            mask    <= mask & (mask - 16'd1);
                            LSM_END <= (count == 5'd2);
                        end
                    end
                end
                CMD_CLEAR: begin
                    state   <= ST_IDLE;
                    mask    <= '0;
                    count   <= '0;
                    ADDR    <= '0;
                    LSM_END <= 1'b0;
                    BUSY    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Self-checking bench for lsm_sequencer: directed vector table, hand-written
// reset/decode sequence, then randomized commands against a transfer-list model.
module tb_lsm_sequencer;

    localparam logic [2:0] C_NOP   = 3'b000;
    localparam logic [2:0] C_LOAD  = 3'b001;
    localparam logic [2:0] C_NEXT  = 3'b010;
    localparam logic [2:0] C_CLEAR = 3'b011;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] IR;
    logic [31:0] RN_VAL;
    logic        LSM_EN;
    logic [2:0]  LSM_IN;
    logic        LSM_DETECT;
    logic        LSM_END;
    logic        BUSY;
    logic [3:0]  REG_NUM;
    logic [31:0] ADDR;
    logic [31:0] WB_VAL;

    int n_checks = 0;
    int n_errors = 0;

    lsm_sequencer dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IR         (IR),
        .RN_VAL     (RN_VAL),
        .LSM_EN     (LSM_EN),
        .LSM_IN     (LSM_IN),
        .LSM_DETECT (LSM_DETECT),
        .LSM_END    (LSM_END),
        .BUSY       (BUSY),
        .REG_NUM    (REG_NUM),
        .ADDR       (ADDR),
        .WB_VAL     (WB_VAL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        en;
        logic [2:0]  cmd;
        logic [31:0] ir;
        logic [31:0] rn;
        logic        e_end;
        logic        e_busy;
        logic [3:0]  e_reg;
        logic [31:0] e_addr;
        logic [31:0] e_wb;
    } vec_t;

    vec_t vecs[$];

    // Reference model: the transfer list is materialised at LOAD as the
    // ascending register numbers; position m_idx walks it upwards in memory.
    int          m_state;   // 0 idle, 1 active, 2 done
    int          m_regs[$];
    int          m_idx;
    logic [31:0] m_lo;
    logic [31:0] m_wb;

    task automatic model_reset();
        m_state = 0;
        m_regs.delete();
        m_idx = 0;
        m_lo  = '0;
        m_wb  = '0;
    endtask

    task automatic model_step(input logic en, input logic [2:0] cmd,
                              input logic [31:0] ir, input logic [31:0] rn);
        logic [31:0] bytes;
        if (!en) return;
        if (cmd == C_LOAD) begin
            m_regs.delete();
            for (int i = 0; i < 16; i++) if (ir[i]) m_regs.push_back(i);
            bytes = 32'(4 * m_regs.size());
            if (ir[23]) m_lo = rn + (ir[24] ? 32'd4 : 32'd0);
            else        m_lo = rn - bytes + (ir[24] ? 32'd0 : 32'd4);
            m_wb    = ir[23] ? rn + bytes : rn - bytes;
            m_idx   = 0;
            m_state = (m_regs.size() > 0) ? 1 : 2;
        end else if (cmd == C_NEXT && m_state == 1) begin
            m_idx++;
            if (m_idx == m_regs.size()) m_state = 2;
        end else if (cmd == C_CLEAR) begin
            m_state = 0;
        end
    endtask

    task automatic model_outputs(output logic e_end, output logic e_busy,
                                 output logic [3:0] e_reg, output logic [31:0] e_addr);
        e_end = 1'b0; e_busy = 1'b0; e_reg = '0; e_addr = '0;
        if (m_state == 1) begin
            e_busy = 1'b1;
            e_reg  = 4'(m_regs[m_idx]);
            e_addr = m_lo + 32'(4 * m_idx);
            e_end  = (m_idx == m_regs.size() - 1);
        end else if (m_state == 2) begin
            e_end  = 1'b1;
            e_addr = m_lo + 32'(4 * m_idx);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_end, input logic e_busy,
                                 input logic [3:0] e_reg, input logic [31:0] e_addr,
                                 input logic [31:0] e_wb);
        check({tag, ".lsm_end"}, 32'(LSM_END), 32'(e_end));
        check({tag, ".busy"},    32'(BUSY),    32'(e_busy));
        check({tag, ".reg_num"}, 32'(REG_NUM), 32'(e_reg));
        check({tag, ".addr"},    ADDR,         e_addr);
        check({tag, ".wb_val"},  WB_VAL,       e_wb);
    endtask

    // Drive at the falling edge, let the rising edge sample, compare at the next fall.
    task automatic drive(input logic en, input logic [2:0] cmd,
                         input logic [31:0] ir, input logic [31:0] rn);
        LSM_EN = en; LSM_IN = cmd; IR = ir; RN_VAL = rn;
        @(posedge CLK);
        model_step(en, cmd, ir, rn);
        @(negedge CLK);
    endtask

    function automatic vec_t mk(input logic en, input logic [2:0] cmd, input logic [31:0] ir,
                                input logic [31:0] rn, input logic e_end, input logic e_busy,
                                input logic [3:0] e_reg, input logic [31:0] e_addr,
                                input logic [31:0] e_wb);
        vec_t v;
        v.en = en; v.cmd = cmd; v.ir = ir; v.rn = rn;
        v.e_end = e_end; v.e_busy = e_busy; v.e_reg = e_reg; v.e_addr = e_addr; v.e_wb = e_wb;
        return v;
    endfunction

    initial begin
        logic        e_end, e_busy;
        logic [3:0]  e_reg;
        logic [31:0] e_addr;
        logic [31:0] list_bits;

        // IA 0x000F from 0x100; NEXT rows carry junk IR/RN that must be ignored
        vecs.push_back(mk(1, C_LOAD,  32'hE880_000F, 32'h100,       0, 1, 0,  32'h100, 32'h110));
        vecs.push_back(mk(1, C_NEXT,  32'h0,         32'hDEAD_BEEF, 0, 1, 1,  32'h104, 32'h110));
        vecs.push_back(mk(1, C_NEXT,  32'hFFFF_FFFF, 32'h0,         0, 1, 2,  32'h108, 32'h110));
        vecs.push_back(mk(1, C_NEXT,  32'h0,         32'h0,         1, 1, 3,  32'h10C, 32'h110));
        vecs.push_back(mk(1, C_NEXT,  32'h0,         32'h0,         1, 0, 0,  32'h110, 32'h110));
        vecs.push_back(mk(1, C_NEXT,  32'h0,         32'h0,         1, 0, 0,  32'h110, 32'h110));
        // DB sparse 0x8001 from 0x200
        vecs.push_back(mk(1, C_LOAD,  32'hE900_8001, 32'h200,       0, 1, 0,  32'h1F8, 32'h1F8));
        vecs.push_back(mk(1, C_NEXT,  32'h0,         32'h0,         1, 1, 15, 32'h1FC, 32'h1F8));
        vecs.push_back(mk(1, C_NEXT,  32'h0,         32'h0,         1, 0, 0,  32'h200, 32'h1F8));
        // DA 0x0007 from 0x4, wrapping below zero
        vecs.push_back(mk(1, C_LOAD,  32'hE800_0007, 32'h4,         0, 1, 0,  32'hFFFF_FFFC, 32'hFFFF_FFF8));
        vecs.push_back(mk(1, C_NEXT,  32'h0,         32'h0,         0, 1, 1,  32'h0,         32'hFFFF_FFF8));
        // hold: LSM_EN low with NEXT pending for three cycles
        vecs.push_back(mk(0, C_NEXT,  32'h0,         32'h0,         0, 1, 1,  32'h0,         32'hFFFF_FFF8));
        vecs.push_back(mk(0, C_NEXT,  32'h0,         32'h0,         0, 1, 1,  32'h0,         32'hFFFF_FFF8));
        vecs.push_back(mk(0, C_NEXT,  32'h0,         32'h0,         0, 1, 1,  32'h0,         32'hFFFF_FFF8));
        vecs.push_back(mk(1, C_NEXT,  32'h0,         32'h0,         1, 1, 2,  32'h4,         32'hFFFF_FFF8));
        // CLEAR keeps WB_VAL; NEXT in IDLE is ignored
        vecs.push_back(mk(1, C_CLEAR, 32'h0,         32'h0,         0, 0, 0,  32'h0,         32'hFFFF_FFF8));
        vecs.push_back(mk(1, C_NEXT,  32'h0,         32'h0,         0, 0, 0,  32'h0,         32'hFFFF_FFF8));
        // IB empty list: straight to DONE; NEXT and a 1xx command change nothing
        vecs.push_back(mk(1, C_LOAD,  32'hE980_0000, 32'h40,        1, 0, 0,  32'h44,        32'h40));
        vecs.push_back(mk(1, C_NEXT,  32'h0,         32'h0,         1, 0, 0,  32'h44,        32'h40));
        vecs.push_back(mk(1, 3'b110,  32'h0,         32'h0,         1, 0, 0,  32'h44,        32'h40));
        // full list IB from 0, then a LOAD mid-sequence restarts
        vecs.push_back(mk(1, C_LOAD,  32'hE980_FFFF, 32'h0,         0, 1, 0,  32'h4,         32'h40));
        vecs.push_back(mk(1, C_NEXT,  32'h0,         32'h0,         0, 1, 1,  32'h8,         32'h40));
        vecs.push_back(mk(1, C_LOAD,  32'hE900_8001, 32'h200,       0, 1, 0,  32'h1F8,       32'h1F8));

        model_reset();
        RST_N = 1'b0; LSM_EN = 1'b0; LSM_IN = C_NOP; IR = '0; RN_VAL = '0;
        @(negedge CLK);
        check_outputs("reset", 0, 0, 0, 32'h0, 32'h0);
        RST_N = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].cmd, vecs[i].ir, vecs[i].rn);
            check_outputs($sformatf("vec%0d", i), vecs[i].e_end, vecs[i].e_busy,
                          vecs[i].e_reg, vecs[i].e_addr, vecs[i].e_wb);
        end

        // Asynchronous reset between edges mid-sequence; decode stays live.
        drive(1, C_LOAD, 32'hE880_000F, 32'h100);
        drive(1, C_NEXT, 32'h0, 32'h0);
        #2 RST_N = 1'b0;
        model_reset();
        #1 check_outputs("async_reset", 0, 0, 0, 32'h0, 32'h0);
        IR = 32'hE8BD_000F;
        #1 check("detect_ldm", 32'(LSM_DETECT), 32'd1);
        IR = 32'hE590_0000;
        #1 check("detect_ldr", 32'(LSM_DETECT), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Randomized commands against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        en;
            logic [2:0]  cmd;
            logic [31:0] ir, rn;
            int          r;
            en = ($urandom_range(0, 9) != 0);
            r  = $urandom_range(0, 99);
            if      (r < 10) cmd = C_LOAD;
            else if (r < 75) cmd = C_NEXT;
            else if (r < 78) cmd = C_CLEAR;
            else if (r < 88) cmd = C_NOP;
            else             cmd = 3'(4 + $urandom_range(0, 3));
            ir = $urandom();
            case ($urandom_range(0, 4))
                0:       list_bits = 32'h0;
                1:       list_bits = 32'h1 << $urandom_range(0, 15);
                2:       list_bits = 32'hFFFF;
                3:       list_bits = $urandom() & $urandom() & 32'hFFFF;
                default: list_bits = $urandom() & 32'hFFFF;
            endcase
            ir[15:0] = list_bits[15:0];
            rn = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 64)) : $urandom();
            drive(en, cmd, ir, rn);
            model_outputs(e_end, e_busy, e_reg, e_addr);
            check_outputs($sformatf("rnd%0d", cyc), e_end, e_busy, e_reg, e_addr, m_wb);
            check($sformatf("rnd%0d.detect", cyc), 32'(LSM_DETECT), 32'(ir[27:25] == 3'b100));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lsm_sequencer.md
# lsm_sequencer

Load/store-multiple (LDM/STM) sequencer that feeds the microprogrammed control unit's LSM_DETECT and LSM_END branch conditions. It walks the 16-bit register list in IR and supplies the current register number, transfer address and base write-back value to the datapath. It advances one step per microcode command issued through the control word's LSM_EN and LSM_IN2..LSM_IN0 bits.

## Interface
- No parameters.
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IR  in  32  current instruction register.
- RN_VAL  in  32  value of base register Rn from the register file.
- LSM_EN  in  1  command strobe from the control word; when 0, all state holds.
- LSM_IN  in  3  command from the control word (LSM_IN2..LSM_IN0): 000 NOP, 001 LOAD, 010 NEXT, 011 CLEAR, 1xx NOP.
- LSM_DETECT  out  1  combinational; 1 when IR[27:25] = 3'b100 (LDM/STM class).
- LSM_END  out  1  current transfer is the last one, or the list is empty.
- BUSY  out  1  sequencer is in ACTIVE.
- REG_NUM  out  4  register number of the current transfer (lowest set bit of the remaining mask).
- ADDR  out  32  memory address of the current transfer.
- WB_VAL  out  32  base write-back value, latched at LOAD.

## Operation
- State: IDLE, ACTIVE, DONE.
- Registers:
  - 16-bit remaining mask.
  - 5-bit remaining count.
  - 32-bit address.
  - 32-bit write-back value.
- LOAD (from any state):
  - Mask is set to IR[15:0].
  - Count is set to the popcount of IR[15:0], range 0..16.
  - N is the loaded count; 4N is a 7-bit quantity, zero-extended to 32 bits.
  - Start address is selected by IR[24:23] (P,U):
    - 01 IA: RN_VAL.
    - 11 IB: RN_VAL+4.
    - 00 DA: RN_VAL−4N+4.
    - 10 DB: RN_VAL−4N.
  - WB_VAL is RN_VAL+4N when U=1, and RN_VAL−4N when U=0.
  - All arithmetic is modulo 2^32, with silent wrap.
  - Next state is ACTIVE if N>0. If N=0, next state is DONE and WB_VAL = RN_VAL.
- NEXT in ACTIVE:
  - Clear the lowest set bit of the mask.
  - Count is decremented by 1.
  - ADDR is incremented by 4 (wrapping).
  - If the count was 1, the state goes to DONE and the mask becomes 0.
- NEXT in IDLE or DONE: ignored.
- CLEAR: go to IDLE. Mask, count and ADDR become 0. WB_VAL holds its value.
- Transfer order:
  - Registers are always transferred in ascending register number.
  - Addresses always ascend, so the lowest register goes to the lowest address, regardless of the U bit.
- REG_NUM is a priority encode (lowest index) of the mask; it is 0 when the mask is 0.
- LSM_END = (ACTIVE and count==1) or DONE.
- BUSY = ACTIVE.
- LSM_DETECT depends only on IR; it is independent of the state machine.

## Timing
- Reset (asynchronous, RST_N=0):
  - State goes to IDLE.
  - Mask, count, ADDR, WB_VAL, REG_NUM, LSM_END and BUSY all go to 0.
  - LSM_DETECT still follows IR.
- Reset mid-sequence aborts immediately. There is no resume.
- Command latency:
  - A command is sampled at the rising edge where LSM_EN=1.
  - Its effect on REG_NUM, ADDR, LSM_END and BUSY is visible after that edge, i.e. the same cycle in which the control unit's next microinstruction sees it.
- One command per cycle. Back-to-back NEXT on consecutive edges is legal.
- IR and RN_VAL must be stable only at the LOAD edge. Later changes to them do not affect the sequence.
- A LOAD while ACTIVE restarts from the new IR/RN_VAL. The in-flight sequence is discarded.
- LSM_EN=0 with any LSM_IN value: full hold.

## Test plan
- IA sequence:
  - Stimulus: IR[24:23]=01, IR[15:0]=0x000F, RN_VAL=0x100; LOAD then 3×NEXT.
  - Required: ADDR 0x100/0x104/0x108/0x10C and REG_NUM 0/1/2/3.
  - Required: LSM_END=1 only on the 4th step; WB_VAL=0x110.
  - Required: a 4th NEXT leads to DONE, BUSY=0.
- DB sparse list:
  - Stimulus: IR[24:23]=10, list 0x8001, RN_VAL=0x200.
  - Required: ADDR 0x1F8 with REG_NUM 0, then 0x1FC with REG_NUM 15.
  - Required: LSM_END on the second step; WB_VAL=0x1F8.
- DA wrap-around:
  - Stimulus: IR[24:23]=00, list 0x0007, RN_VAL=0x4.
  - Required: ADDR 0xFFFFFFFC, 0x00000000, 0x00000004; WB_VAL=0xFFFFFFF8.
- Empty list and IB:
  - Stimulus: IR[24:23]=11, list 0x0000, RN_VAL=0x40; LOAD.
  - Required: next cycle DONE, LSM_END=1, BUSY=0, WB_VAL=0x40.
  - Required: a subsequent NEXT changes nothing.
- Hold, CLEAR and reset:
  - Stimulus: mid-sequence LSM_EN=0 with LSM_IN=010 for 3 cycles.
  - Required: outputs frozen during those cycles.
  - Stimulus: CLEAR.
  - Required: IDLE, ADDR=0, WB_VAL kept.
  - Stimulus: new LOAD, then RST_N low between clock edges.
  - Required: all outputs 0 immediately.
- Decode:
  - Stimulus: IR=0xE8BD000F.
  - Required: LSM_DETECT=1.
  - Stimulus: IR=0xE5900000.
  - Required: LSM_DETECT=0.
